ps2_host_tx: RTL

- PS/2 host-to-device transmitter. It is the opposite direction of the keyboard receive path, which uses the PS/2 filter and `serial2parallel`.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs followed by the LED mask byte, or 0xFF reset.
- Drives the PS2_CLK and PS2_DATA lines as open-drain pull-downs, following the PS/2 host-request-to-send sequence.
- Sits beside the receive path in MiniAlu. It is fed by a future ALU opcode through a strobe and handshake.

---
 rtl/ps2_host_tx.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out one byte, check the device ACK.
// Optional watchdog on a silent device: define PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iSend,
  output logic       oBusy,
  output logic       oDone,
  output logic       oError,
  input  logic       iPS2Clk,
  input  logic       iPS2Data,
  output logic       oPS2ClkLow,
  output logic       oPS2DataLow
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

  if (FILTER_LEN < 2 || INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("ps2_host_tx: FILTER_LEN>=2, INHIBIT_CYCLES>=1 and TIMEOUT_CYCLES>=2 are required");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5,
    FAIL      = 3'd6
  } state_t;

  state_t state, stateNext;

  // Glitch filters: the level only changes once the whole window agrees.
  logic [FILTER_LEN-1:0] clkSr, dataSr;
  logic                  fClk, fData, fClkD;
  logic                  fClkFall;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      clkSr  <= '1;
      dataSr <= '1;
      fClk   <= 1'b1;
      fData  <= 1'b1;
      fClkD  <= 1'b1;
    end else begin
      clkSr  <= {clkSr[FILTER_LEN-2:0], iPS2Clk};
      dataSr <= {dataSr[FILTER_LEN-2:0], iPS2Data};
      if (&clkSr)       fClk <= 1'b1;
      else if (~|clkSr) fClk <= 1'b0;
      if (&dataSr)       fData <= 1'b1;
      else if (~|dataSr) fData <= 1'b0;
      fClkD <= fClk;
    end
  end

  assign fClkFall = fClkD & ~fClk;

  logic timeout;

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wdCnt;

  // Runs from the end of the inhibit phase until the ACK has been sampled.
  always_ff @(posedge Clock) begin
    if (!Reset || state == IDLE) begin
      wdCnt <= '0;
    end else if (state inside {REQ, SHIFT, ACK}) begin
      wdCnt <= wdCnt + TO_W'(1);
    end
  end

  assign timeout = (state inside {REQ, SHIFT, ACK}) && (wdCnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // frame[0] is the next bit to present; stop bit sits on top and ones fill behind it.
  logic [9:0]       frame, frameNext;
  logic [3:0]       bitCnt, bitCntNext;
  logic [INH_W-1:0] inhCnt, inhCntNext;
  logic             busyNext, doneNext, errorNext, clkLowNext, dataLowNext;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state       <= IDLE;
      frame       <= '0;
      bitCnt      <= '0;
      inhCnt      <= '0;
      oBusy       <= 1'b0;
      oDone       <= 1'b0;
      oError      <= 1'b0;
      oPS2ClkLow  <= 1'b0;
      oPS2DataLow <= 1'b0;
    end else begin
      state       <= stateNext;
      frame       <= frameNext;
      bitCnt      <= bitCntNext;
      inhCnt      <= inhCntNext;
      oBusy       <= busyNext;
      oDone       <= doneNext;
      oError      <= errorNext;
      oPS2ClkLow  <= clkLowNext;
      oPS2DataLow <= dataLowNext;
    end
  end

  always_comb begin
    stateNext   = state;
    frameNext   = frame;
    bitCntNext  = bitCnt;
    inhCntNext  = inhCnt;
    busyNext    = oBusy;
    doneNext    = 1'b0;
    errorNext   = 1'b0;
    clkLowNext  = 1'b0;
    dataLowNext = oPS2DataLow;

    case (state)
      IDLE: begin
        busyNext    = 1'b0;
        dataLowNext = 1'b0;
        // oBusy is still high in the oDone/oError cycle, so a strobe there is dropped.
        if (iSend && !oBusy) begin
          frameNext  = {1'b1, ~^iData, iData};
          bitCntNext = '0;
          inhCntNext = '0;
          busyNext   = 1'b1;
          clkLowNext = 1'b1;
          stateNext  = INHIBIT;
        end
      end
      INHIBIT: begin
        clkLowNext = 1'b1;
        inhCntNext = inhCnt + INH_W'(1);
        if (inhCnt == INH_W'(INHIBIT_CYCLES - 1)) begin
          dataLowNext = 1'b1;
          stateNext   = REQ;
        end
      end
      REQ: begin
        dataLowNext = 1'b1;
        stateNext   = SHIFT;
      end
      SHIFT: begin
        if (fClkFall) begin
          dataLowNext = ~frame[0];
          frameNext   = {1'b1, frame[9:1]};
          bitCntNext  = bitCnt + 4'd1;
          if (bitCnt == 4'd9) stateNext = ACK;
        end
      end
      ACK: begin
        dataLowNext = 1'b0;
        if (fClkFall) stateNext = fData ? FAIL : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        dataLowNext = 1'b0;
        if (fClk && fData) begin
          doneNext  = 1'b1;
          stateNext = IDLE;
        end
      end
      FAIL: begin
        dataLowNext = 1'b0;
        errorNext   = 1'b1;
        stateNext   = IDLE;
      end
      default: begin
        dataLowNext = 1'b0;
        stateNext   = IDLE;
      end
    endcase

    if (timeout) begin
      clkLowNext  = 1'b0;
      dataLowNext = 1'b0;
      stateNext   = FAIL;
    end
  end

endmodule
